// File: rtl/dmem_req_arbiter_pkg.sv
// Shared types, command encodings and the round-robin pick helper for the
// data-memory request arbiter.
package dmem_arb_pkg;

  localparam int TAG_W    = 7;
  localparam int MAX_NREQ = 4;

  typedef enum logic [4:0] {
    M_XRD     = 5'b00000,
    M_XWR     = 5'b00001,
    M_PFR     = 5'b00010,
    M_PFW     = 5'b00011,
    M_XA_SWAP = 5'b00100,
    M_FLUSH   = 5'b00101,
    M_XLR     = 5'b00110,
    M_XSC     = 5'b00111
  } mem_cmd_e;

  typedef struct packed {
    logic [31:0]      addr;
    logic [TAG_W-1:0] tag;
    logic [4:0]       cmd;
    logic [1:0]       size;
    logic             is_signed;
    logic [1:0]       dprv;
    logic             phys;
    logic             no_alloc;
    logic             no_xcpt;
    logic [31:0]      data;
    logic [3:0]       mask;
  } dmem_req_t;

  // First eligible index at or after ptr, wrapping modulo nreq; returns ptr
  // when nothing is eligible (the caller qualifies with any-eligible).
  function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] eligible,
                                          input logic [1:0]          ptr,
                                          input int unsigned         nreq);
    int unsigned idx;
    logic        found;
    rr_pick = 32'(ptr);
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (!found && i < nreq && ((eligible >> idx) & 4'b0001) != 4'b0000) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dmem_req_arbiter_if.sv
// Requester-side, cache-side and response-routing signals of the arbiter.
// slave is the arbiter's view; master is the surrounding core's view.
interface dmem_req_arbiter_if #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) ();
  import dmem_arb_pkg::*;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  dmem_req_t [NREQ-1:0]        req_bits;
  logic                        mem_valid;
  logic                        mem_ready;
  dmem_req_t                   mem_bits;
  logic                        resp_valid;
  logic [TAG_W-1:0]            resp_tag;
  logic                        nack_valid;
  logic [TAG_W-1:0]            nack_tag;
  logic [NREQ-1:0]             rsp_valid_o;
  logic [NREQ-1:0]             nack_o;
  logic [TAG_W-IDW-1:0]        rsp_tag_o;

  modport slave (
    input  req_valid, req_bits, mem_ready, resp_valid, resp_tag, nack_valid, nack_tag,
    output req_ready, mem_valid, mem_bits, rsp_valid_o, nack_o, rsp_tag_o
  );

  modport master (
    output req_valid, req_bits, mem_ready, resp_valid, resp_tag, nack_valid, nack_tag,
    input  req_ready, mem_valid, mem_bits, rsp_valid_o, nack_o, rsp_tag_o
  );

endinterface

// File: rtl/dmem_arb_outstanding_ctr.sv
// Per-requester outstanding-transaction counter: +1 on accept, -0/1/2 on
// completions, floored at zero with an underflow flag.
module dmem_arb_outstanding_ctr #(
  parameter  int MAX_OUT = 4,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc_i,
  input  logic [1:0]    dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q, cnt_d, base;

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    underflow_o = 32'(dec_i) > 32'(cnt_q);
    base        = underflow_o ? '0 : cnt_q - CW'(dec_i);
    cnt_d       = base + CW'(inc_i);
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked block.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = 32'(cnt_q) >= MAX_OUT;

endmodule

// File: rtl/dmem_req_arbiter.sv
// Round-robin arbiter sharing one data-cache request port among NREQ
// requesters, routing responses/nacks back by the id held in the upper tag bits.
module dmem_req_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int MAX_OUT = 4,
  localparam int IDW     = $clog2(NREQ),
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  dmem_req_arbiter_if.slave      bus,
  input  logic                   quiesce,
  output logic                   idle,
  output logic                   err
);

  logic [NREQ-1:0]         eligible, full, uflow, req_ready, rsp_hit, nack_hit;
  logic [NREQ-1:0][CW-1:0] cnt;
  logic [NREQ-1:0][1:0]    dec;
  logic [IDW-1:0]          ptr_q, grant_q, grant, resp_id, nack_id;
  logic                    lock_q, err_q, mem_valid, resp_ok, nack_ok, bad_id, all_zero;
  dmem_req_t               mem_req;

  assign resp_id = bus.resp_tag[TAG_W-1 -: IDW];
  assign nack_id = bus.nack_tag[TAG_W-1 -: IDW];

  always_comb begin
    eligible  = bus.req_valid & ~full & {NREQ{~quiesce}};
    // A pending grant is frozen until its handshake, even under quiesce.
    grant     = lock_q ? grant_q : IDW'(rr_pick(4'(eligible), 2'(ptr_q), NREQ));
    mem_valid = (|eligible) | lock_q;
    mem_req   = bus.req_bits[grant];
    mem_req.tag[TAG_W-1 -: IDW] = grant;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = bus.mem_ready && mem_valid && (grant == IDW'(i));
    end
  end

  assign bus.mem_valid = mem_valid;
  assign bus.mem_bits  = mem_req;
  assign bus.req_ready = req_ready;

  always_comb begin
    resp_ok  = bus.resp_valid && (32'(resp_id) < NREQ);
    nack_ok  = bus.nack_valid && (32'(nack_id) < NREQ);
    bad_id   = (bus.resp_valid && !resp_ok) || (bus.nack_valid && !nack_ok);
    all_zero = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rsp_hit[i]  = resp_ok && (resp_id == IDW'(i));
      nack_hit[i] = nack_ok && (nack_id == IDW'(i));
      dec[i]      = {1'b0, rsp_hit[i]} + {1'b0, nack_hit[i]};
      if (cnt[i] != '0) all_zero = 1'b0;
    end
  end

  assign bus.rsp_valid_o = rsp_hit;
  assign bus.nack_o      = nack_hit;
  assign bus.rsp_tag_o   = bus.resp_valid ? bus.resp_tag[TAG_W-IDW-1:0]
                                          : bus.nack_tag[TAG_W-IDW-1:0];
  assign idle            = all_zero && !mem_valid;
  assign err             = err_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_ctr
    dmem_arb_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_ctr (
      .clock       (clock),
      .reset       (reset),
      .inc_i       (req_ready[g]),
      .dec_i       (dec[g]),
      .cnt_o       (cnt[g]),
      .full_o      (full[g]),
      .underflow_o (uflow[g])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (mem_valid && bus.mem_ready) begin
        ptr_q  <= (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        lock_q <= 1'b0;
      end else if (mem_valid) begin
        lock_q  <= 1'b1;
        grant_q <= grant;
      end
      if ((|uflow) || bad_id) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Directed bench for dmem_req_arbiter (NREQ=2, MAX_OUT=4) with hand-computed
// expectations for grants, tags, routing, counts, err and idle.
module tb_dmem_req_arbiter;
  import dmem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic quiesce;
  logic idle;
  logic err;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_req_arbiter_if #(.NREQ(2)) bus ();

  dmem_req_arbiter #(.NREQ(2), .MAX_OUT(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .quiesce (quiesce),
    .idle    (idle),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [6:0] tag, input logic [31:0] addr);
    dmem_req_t r;
    r      = '0;
    r.addr = addr;
    r.tag  = tag;
    r.cmd  = M_XRD;
    r.size = 2'd2;
    bus.req_bits[i]  = r;
    bus.req_valid[i] = v;
  endtask

  task automatic set_cpl(input logic rv, input logic [6:0] rt, input logic nv, input logic [6:0] nt);
    bus.resp_valid = rv;
    bus.resp_tag   = rt;
    bus.nack_valid = nv;
    bus.nack_tag   = nt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    quiesce       = 1'b0;
    bus.mem_ready = 1'b0;
    set_req(0, 1'b0, 7'h00, 32'h0);
    set_req(1, 1'b0, 7'h00, 32'h0);
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    do_reset();

    check("rst_mem_valid", 32'(bus.mem_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_err", 32'(err), 0);

    // Single requester: three loads, then three responses.
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 7'(k), 32'h1000 + 32'(4 * k));
      settle();
      check("single_ready", 32'(bus.req_ready), 32'b01);
      check("single_tag", 32'(bus.mem_bits.tag), 32'(k));
      step();
    end
    set_req(0, 1'b0, 7'h00, 32'h0);
    settle();
    check("single_cnt0", 32'(dut.g_ctr[0].u_ctr.cnt_o), 3);
    check("single_not_idle", 32'(idle), 0);
    for (int k = 0; k < 3; k++) begin
      set_cpl(1'b1, 7'(k), 1'b0, 7'h00);
      settle();
      check("single_rsp", 32'(bus.rsp_valid_o), 32'b01);
      check("single_rsp_tag", 32'(bus.rsp_tag_o), 32'(k));
      step();
    end
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("single_cnt0_done", 32'(dut.g_ctr[0].u_ctr.cnt_o), 0);
    check("single_idle", 32'(idle), 1);

    // Both requesters continuously valid from ptr=0: grants 0,1,0,1.
    do_reset();
    set_req(0, 1'b1, 7'h03, 32'h2000);
    set_req(1, 1'b1, 7'h05, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      check("rr_tag", 32'(bus.mem_bits.tag), (k % 2 == 0) ? 32'h03 : 32'h45);
      step();
    end
    set_req(0, 1'b0, 7'h03, 32'h2000);
    set_req(1, 1'b0, 7'h05, 32'h3000);
    // Resp to 0 and nack to 1 in the same cycle, twice.
    for (int k = 0; k < 2; k++) begin
      set_cpl(1'b1, 7'h03, 1'b1, 7'h45);
      settle();
      check("dual_rsp", 32'(bus.rsp_valid_o), 32'b01);
      check("dual_nack", 32'(bus.nack_o), 32'b10);
      step();
    end
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("dual_idle", 32'(idle), 1);

    // Lock: grant 1 held under backpressure although 0 is next by ptr.
    bus.mem_ready = 1'b0;
    set_req(1, 1'b1, 7'h07, 32'hA1A1_0000);
    settle();
    check("lock_valid", 32'(bus.mem_valid), 1);
    check("lock_tag0", 32'(bus.mem_bits.tag), 32'h47);
    step();
    set_req(0, 1'b1, 7'h08, 32'hB0B0_0000);
    for (int k = 0; k < 2; k++) begin
      settle();
      check("lock_hold_tag", 32'(bus.mem_bits.tag), 32'h47);
      check("lock_hold_addr", bus.mem_bits.addr, 32'hA1A1_0000);
      check("lock_hold_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.mem_ready = 1'b1;
    settle();
    check("lock_hs_ready", 32'(bus.req_ready), 32'b10);
    step();
    set_req(1, 1'b0, 7'h07, 32'h0);
    settle();
    check("lock_after_ready", 32'(bus.req_ready), 32'b01);
    check("lock_after_tag", 32'(bus.mem_bits.tag), 32'h08);
    set_req(0, 1'b0, 7'h08, 32'h0);
    set_cpl(1'b1, 7'h47, 1'b0, 7'h00);
    step();
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("lock_drain_idle", 32'(idle), 1);

    // MAX_OUT=4 on requester 0.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 7'h10, 32'h4000);
      settle();
      check("max_ready", 32'(bus.req_ready), 32'b01);
      step();
    end
    check("max_cnt0", 32'(dut.g_ctr[0].u_ctr.cnt_o), 4);
    check("max_blocked", 32'(bus.mem_valid), 0);
    set_req(1, 1'b1, 7'h11, 32'h5000);
    settle();
    check("max_other_served", 32'(bus.req_ready), 32'b10);
    step();
    set_req(1, 1'b0, 7'h11, 32'h0);
    set_cpl(1'b1, 7'h10, 1'b0, 7'h00);
    settle();
    check("max_still_full", 32'(bus.req_ready), 0);
    step();
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("max_regrant", 32'(bus.req_ready), 32'b01);
    set_req(0, 1'b0, 7'h10, 32'h0);
    settle();

    // Accept on 0 with same-cycle resp(0) and nack(1): cnt0 3->3, cnt1 1->0.
    set_req(0, 1'b1, 7'h12, 32'h6000);
    set_cpl(1'b1, 7'h00, 1'b1, 7'h41);
    settle();
    check("net_ready", 32'(bus.req_ready), 32'b01);
    check("net_rsp", 32'(bus.rsp_valid_o), 32'b01);
    check("net_nack", 32'(bus.nack_o), 32'b10);
    check("net_rsp_tag", 32'(bus.rsp_tag_o), 0);
    step();
    set_req(0, 1'b0, 7'h12, 32'h0);
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("net_cnt0", 32'(dut.g_ctr[0].u_ctr.cnt_o), 3);
    check("net_cnt1", 32'(dut.g_ctr[1].u_ctr.cnt_o), 0);
    check("net_no_err", 32'(err), 0);

    // Response to requester 1 with nothing outstanding: sticky err.
    set_cpl(1'b1, 7'h41, 1'b0, 7'h00);
    settle();
    check("uflow_rsp", 32'(bus.rsp_valid_o), 32'b10);
    step();
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("uflow_err", 32'(err), 1);
    check("uflow_cnt1_sat", 32'(dut.g_ctr[1].u_ctr.cnt_o), 0);
    repeat (2) step();
    check("uflow_err_sticky", 32'(err), 1);

    // Quiesce with two outstanding on requester 0.
    set_cpl(1'b1, 7'h00, 1'b0, 7'h00);
    step();
    quiesce = 1'b1;
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    set_req(0, 1'b1, 7'h20, 32'h7000);
    set_req(1, 1'b1, 7'h21, 32'h8000);
    settle();
    check("q_no_valid", 32'(bus.mem_valid), 0);
    check("q_no_ready", 32'(bus.req_ready), 0);
    check("q_not_idle", 32'(idle), 0);
    set_cpl(1'b1, 7'h00, 1'b0, 7'h00);
    step();
    settle();
    check("q_one_left_idle", 32'(idle), 0);
    step();
    set_cpl(1'b0, 7'h00, 1'b0, 7'h00);
    settle();
    check("q_idle_rises", 32'(idle), 1);
    check("q_err_held", 32'(err), 1);

    quiesce = 1'b0;
    set_req(0, 1'b0, 7'h00, 32'h0);
    set_req(1, 1'b0, 7'h00, 32'h0);
    do_reset();
    check("final_err_cleared", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
